// File: rtl/uart_tx_mux_if.sv
// Write-request bus into uart_tx_mux: (address, data) strobe plus FIFO status.
interface uart_tx_mux_if;
  logic       in_write;
  logic [7:0] in_addr;
  logic [7:0] in_data;
  logic       full;
  logic       overflow;
  logic       busy;

  modport master (
    output in_write,
    output in_addr,
    output in_data,
    input  full,
    input  overflow,
    input  busy
  );

  modport slave (
    input  in_write,
    input  in_addr,
    input  in_data,
    output full,
    output overflow,
    output busy
  );
endinterface

// File: rtl/uart_tx_mux.sv
// uart_tx_mux: queues (addr, data) write requests in a small FIFO and sends
// each one on UART_TXD as two 8N1 bytes, address byte first.
module uart_tx_mux #(
  parameter int unsigned DIVISOR    = 186,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  uart_tx_mux_if.slave  req,
  output logic          UART_TXD
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned BW = $clog2(DIVISOR);
  localparam logic [BW-1:0] BAUD_LOAD = BW'(DIVISOR - 1);
  localparam logic [CW-1:0] CNT_FULL  = CW'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [15:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;

  logic [1:0]    state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic          byte_sel_q, byte_sel_d;
  logic [15:0]   hold_q, hold_d;
  logic          txd_q, txd_d;

  logic          full_w, empty_w, push, pop, bit_end;
  logic [7:0]    cur_byte;

  assign full_w  = (count_q == CNT_FULL);
  assign empty_w = (count_q == '0);
  assign push    = req.in_write && !full_w;
  assign bit_end = (baud_q == '0);

  // FIFO bookkeeping: pointers, occupancy and the sticky drop flag.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (req.in_write & full_w);
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Frame sequencer; the line level is derived from the next state so that
  // the registered output lines up with the state it belongs to.
  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_idx_d  = bit_idx_q;
    byte_sel_d = byte_sel_q;
    hold_d     = hold_q;
    pop        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty_w) begin
          pop        = 1'b1;
          hold_d     = mem[rd_ptr_q];
          byte_sel_d = 1'b0;
          baud_d     = BAUD_LOAD;
          state_d    = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          baud_d    = BAUD_LOAD;
          bit_idx_d = 3'd0;
          state_d   = S_DATA;
        end else begin
          baud_d = baud_q - BW'(1);
        end
      end
      S_DATA: begin
        if (bit_end) begin
          baud_d = BAUD_LOAD;
          if (bit_idx_q == 3'd7) state_d = S_STOP;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end else begin
          baud_d = baud_q - BW'(1);
        end
      end
      default: begin
        if (bit_end) begin
          baud_d = BAUD_LOAD;
          if (!byte_sel_q) begin
            byte_sel_d = 1'b1;
            state_d    = S_START;
          end else if (!empty_w) begin
            pop        = 1'b1;
            hold_d     = mem[rd_ptr_q];
            byte_sel_d = 1'b0;
            state_d    = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          baud_d = baud_q - BW'(1);
        end
      end
    endcase

    cur_byte = byte_sel_d ? hold_d[7:0] : hold_d[15:8];
    case (state_d)
      S_START: txd_d = 1'b0;
      S_DATA:  txd_d = cur_byte[bit_idx_d];
      default: txd_d = 1'b1;
    endcase
  end

  // FIFO storage; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= {req.in_addr, req.in_data};
  end

  // State registers with asynchronous reset to the idle, empty condition.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      state_q    <= S_IDLE;
      baud_q     <= '0;
      bit_idx_q  <= '0;
      byte_sel_q <= 1'b0;
      hold_q     <= '0;
      txd_q      <= 1'b1;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_idx_q  <= bit_idx_d;
      byte_sel_q <= byte_sel_d;
      hold_q     <= hold_d;
      txd_q      <= txd_d;
    end
  end

  assign req.full     = full_w;
  assign req.overflow = overflow_q;
  assign req.busy     = (state_q != S_IDLE) || !empty_w;
  assign UART_TXD     = txd_q;

endmodule

// File: tb/tb_uart_tx_mux.sv
// Bench for uart_tx_mux: an independent 8N1 line decoder collects bytes and
// their start times; each scenario compares against expectations it derives.
module tb_uart_tx_mux;
  localparam int DIV   = 4;
  localparam int DEPTH = 4;
  localparam int BYTE_CLK  = 10 * DIV;
  localparam int FRAME_CLK = 20 * DIV;

  logic clk = 1'b0;
  logic reset;
  logic txd;
  uart_tx_mux_if bus ();

  uart_tx_mux #(.DIVISOR(DIV), .FIFO_DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (bus),
    .UART_TXD (txd)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;
  int frm_err = 0;
  logic [7:0] rx_q[$];
  int         rx_st[$];
  logic [7:0] exp_q[$];

  // Line decoder: samples each bit in its middle, discards bytes cut by reset.
  initial begin
    logic [7:0] b;
    logic s_ok, stp;
    bit ab;
    int st;
    forever begin
      @(negedge clk);
      if (reset !== 1'b0 || txd !== 1'b0) continue;
      st = cyc;
      ab = 0;
      repeat (DIV/2) begin @(negedge clk); if (reset) ab = 1; end
      s_ok = (txd === 1'b0);
      for (int j = 0; j < 8; j++) begin
        repeat (DIV) begin @(negedge clk); if (reset) ab = 1; end
        b[j] = txd;
      end
      repeat (DIV) begin @(negedge clk); if (reset) ab = 1; end
      stp = txd;
      if (!ab) begin
        if (!s_ok || stp !== 1'b1) frm_err++;
        rx_q.push_back(b);
        rx_st.push_back(st);
      end
    end
  end

  // Expected line level i clocks into a frame, from the 8N1 rules.
  function automatic logic line_bit(input logic [7:0] a, input logic [7:0] d, input int i);
    int k, p;
    logic [7:0] bb;
    k  = i / BYTE_CLK;
    p  = (i % BYTE_CLK) / DIV;
    bb = (k == 0) ? a : d;
    if (p == 0) return 1'b0;
    if (p == 9) return 1'b1;
    return bb[p-1];
  endfunction

  task automatic drive_write(input logic [7:0] a, input logic [7:0] d);
    bus.in_write = 1'b1;
    bus.in_addr  = a;
    bus.in_data  = d;
    @(negedge clk);
    bus.in_write = 1'b0;
  endtask

  task automatic wait_idle(input int limit, output bit ok);
    ok = 0;
    for (int k = 0; k < limit; k++) begin
      @(negedge clk);
      if (bus.busy === 1'b0) begin ok = 1; break; end
    end
  endtask

  task automatic clear_logs();
    rx_q.delete();
    rx_st.delete();
    exp_q.delete();
    frm_err = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.in_write = 1'b0;
    bus.in_addr  = '0;
    bus.in_data  = '0;
    repeat (3) @(negedge clk);
    tests++; if (txd !== 1'b1)          begin fails++; $display("FAIL reset_txd got %b want 1", txd); end
    tests++; if (bus.full !== 1'b0)     begin fails++; $display("FAIL reset_full got %b want 0", bus.full); end
    tests++; if (bus.overflow !== 1'b0) begin fails++; $display("FAIL reset_overflow got %b want 0", bus.overflow); end
    tests++; if (bus.busy !== 1'b0)     begin fails++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    reset = 1'b0;
    repeat (5) @(negedge clk);
    tests++; if (txd !== 1'b1 || bus.busy !== 1'b0) begin
      fails++; $display("FAIL post_reset_idle txd=%b busy=%b want 1/0", txd, bus.busy);
    end
  endtask

  task automatic test_single_frame();
    clear_logs();
    drive_write(8'h35, 8'h01);
    tests++; if (txd !== 1'b1) begin fails++; $display("FAIL single_latency txd got %b want 1", txd); end
    tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL single_busy_early got %b want 1", bus.busy); end
    for (int i = 0; i < FRAME_CLK; i++) begin
      @(negedge clk);
      tests++;
      if (txd !== line_bit(8'h35, 8'h01, i)) begin
        fails++; $display("FAIL single_wave clk %0d got %b want %b", i, txd, line_bit(8'h35, 8'h01, i));
      end
      if (i % BYTE_CLK == 0) begin
        tests++;
        if (bus.busy !== 1'b1) begin fails++; $display("FAIL single_busy clk %0d got %b want 1", i, bus.busy); end
      end
    end
    @(negedge clk);
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL single_busy_drop got %b want 0", bus.busy); end
    tests++; if (txd !== 1'b1) begin fails++; $display("FAIL single_idle_line got %b want 1", txd); end
    tests++;
    if (rx_q.size() != 2 || rx_q[0] !== 8'h35 || rx_q[1] !== 8'h01 || frm_err != 0) begin
      fails++; $display("FAIL single_decode got %0d bytes err=%0d want 35 01", rx_q.size(), frm_err);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    clear_logs();
    exp_q = '{8'h40, 8'hAA, 8'h41, 8'h55};
    drive_write(8'h40, 8'hAA);
    drive_write(8'h41, 8'h55);
    wait_idle(400, ok);
    tests++; if (!ok) begin fails++; $display("FAIL b2b_timeout busy got 1 want 0"); end
    tests++;
    if (rx_q.size() != 4) begin
      fails++; $display("FAIL b2b_count got %0d want 4", rx_q.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        tests++;
        if (rx_q[k] !== exp_q[k]) begin fails++; $display("FAIL b2b_byte%0d got %h want %h", k, rx_q[k], exp_q[k]); end
      end
      for (int k = 1; k < 4; k++) begin
        tests++;
        if (rx_st[k] - rx_st[k-1] != BYTE_CLK) begin
          fails++; $display("FAIL b2b_gap%0d got %0d want %0d", k, rx_st[k] - rx_st[k-1], BYTE_CLK);
        end
      end
      tests++;
      if (rx_st[3] + BYTE_CLK - rx_st[0] != 2 * FRAME_CLK) begin
        fails++; $display("FAIL b2b_span got %0d want %0d", rx_st[3] + BYTE_CLK - rx_st[0], 2 * FRAME_CLK);
      end
    end
    tests++; if (frm_err != 0) begin fails++; $display("FAIL b2b_framing got %0d want 0", frm_err); end
  endtask

  task automatic test_random_frames();
    bit ok;
    logic [7:0] a, d;
    int n;
    for (int it = 0; it < 6; it++) begin
      clear_logs();
      n = int'($urandom_range(3, 1));
      for (int j = 0; j < n; j++) begin
        a = 8'($urandom_range(255, 0));
        d = 8'($urandom_range(255, 0));
        exp_q.push_back(a);
        exp_q.push_back(d);
        drive_write(a, d);
        repeat ($urandom_range(3, 0)) @(negedge clk);
      end
      wait_idle(n * FRAME_CLK + 50, ok);
      tests++; if (!ok) begin fails++; $display("FAIL rand_timeout it %0d", it); end
      tests++;
      if (rx_q.size() != exp_q.size()) begin
        fails++; $display("FAIL rand_count it %0d got %0d want %0d", it, rx_q.size(), exp_q.size());
      end else begin
        for (int k = 0; k < exp_q.size(); k++) begin
          tests++;
          if (rx_q[k] !== exp_q[k]) begin
            fails++; $display("FAIL rand_byte it %0d idx %0d got %h want %h", it, k, rx_q[k], exp_q[k]);
          end
          if (k > 0) begin
            tests++;
            if (rx_st[k] - rx_st[k-1] != BYTE_CLK) begin
              fails++; $display("FAIL rand_gap it %0d idx %0d got %0d want %0d", it, k, rx_st[k] - rx_st[k-1], BYTE_CLK);
            end
          end
        end
      end
      tests++; if (frm_err != 0) begin fails++; $display("FAIL rand_framing it %0d got %0d want 0", it, frm_err); end
    end
  endtask

  task automatic test_overflow();
    bit ok;
    logic [7:0] a, d;
    clear_logs();
    a = 8'($urandom_range(255, 0));
    d = 8'($urandom_range(255, 0));
    exp_q.push_back(a);
    exp_q.push_back(d);
    drive_write(a, d);
    repeat (3) @(negedge clk);
    for (int j = 0; j < 5; j++) begin
      a = 8'($urandom_range(255, 0));
      d = 8'($urandom_range(255, 0));
      if (j < DEPTH) begin exp_q.push_back(a); exp_q.push_back(d); end
      drive_write(a, d);
      tests++;
      if (bus.full !== (j >= DEPTH - 1)) begin
        fails++; $display("FAIL ovf_full after write %0d got %b want %b", j, bus.full, (j >= DEPTH - 1));
      end
      tests++;
      if (bus.overflow !== (j == DEPTH)) begin
        fails++; $display("FAIL ovf_flag after write %0d got %b want %b", j, bus.overflow, (j == DEPTH));
      end
    end
    wait_idle(6 * FRAME_CLK + 50, ok);
    tests++; if (!ok) begin fails++; $display("FAIL ovf_timeout busy got 1 want 0"); end
    tests++; if (bus.overflow !== 1'b1) begin fails++; $display("FAIL ovf_sticky got %b want 1", bus.overflow); end
    tests++; if (bus.full !== 1'b0) begin fails++; $display("FAIL ovf_full_drain got %b want 0", bus.full); end
    tests++;
    if (rx_q.size() != exp_q.size()) begin
      fails++; $display("FAIL ovf_count got %0d want %0d", rx_q.size(), exp_q.size());
    end else begin
      for (int k = 0; k < exp_q.size(); k++) begin
        tests++;
        if (rx_q[k] !== exp_q[k]) begin fails++; $display("FAIL ovf_byte%0d got %h want %h", k, rx_q[k], exp_q[k]); end
      end
    end
  endtask

  task automatic test_full_same_edge_pop();
    bit ok;
    logic [7:0] a, d;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    clear_logs();
    for (int j = 0; j <= DEPTH; j++) begin
      a = 8'($urandom_range(255, 0));
      d = 8'($urandom_range(255, 0));
      exp_q.push_back(a);
      exp_q.push_back(d);
      drive_write(a, d);
      if (j == 0) repeat (2) @(negedge clk);
    end
    // Negedges since the first write: 1 + 2 + DEPTH; the next pop follows negedge 81.
    repeat (FRAME_CLK + 1 - (3 + DEPTH)) @(negedge clk);
    tests++; if (bus.full !== 1'b1) begin fails++; $display("FAIL pop_edge_full_before got %b want 1", bus.full); end
    tests++; if (bus.overflow !== 1'b0) begin fails++; $display("FAIL pop_edge_ovf_before got %b want 0", bus.overflow); end
    drive_write(8'hEE, 8'hEE);
    tests++; if (bus.overflow !== 1'b1) begin fails++; $display("FAIL pop_edge_ovf got %b want 1", bus.overflow); end
    tests++; if (bus.full !== 1'b0) begin fails++; $display("FAIL pop_edge_full_after got %b want 0", bus.full); end
    wait_idle(6 * FRAME_CLK, ok);
    tests++; if (!ok) begin fails++; $display("FAIL pop_edge_timeout busy got 1 want 0"); end
    tests++;
    if (rx_q.size() != exp_q.size()) begin
      fails++; $display("FAIL pop_edge_count got %0d want %0d", rx_q.size(), exp_q.size());
    end else begin
      for (int k = 0; k < exp_q.size(); k++) begin
        tests++;
        if (rx_q[k] !== exp_q[k]) begin fails++; $display("FAIL pop_edge_byte%0d got %h want %h", k, rx_q[k], exp_q[k]); end
      end
    end
  endtask

  task automatic test_reset_mid_bit();
    bit ok;
    logic [7:0] a, d;
    tests++; if (bus.overflow !== 1'b1) begin fails++; $display("FAIL rst_setup_ovf got %b want 1", bus.overflow); end
    clear_logs();
    a = 8'($urandom_range(255, 0)) & 8'hF7;
    d = 8'($urandom_range(255, 0));
    drive_write(a, d);
    drive_write(8'($urandom_range(255, 0)), 8'($urandom_range(255, 0)));
    drive_write(8'($urandom_range(255, 0)), 8'($urandom_range(255, 0)));
    // Line fell after negedge 1; data bit 3 covers offsets 16..19, sample offset 17.
    repeat (16) @(negedge clk);
    tests++; if (txd !== 1'b0) begin fails++; $display("FAIL rst_pre_bit3 got %b want 0", txd); end
    tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL rst_pre_busy got %b want 1", bus.busy); end
    #1 reset = 1'b1;
    #1;
    tests++; if (txd !== 1'b1)          begin fails++; $display("FAIL rst_mid_txd got %b want 1", txd); end
    tests++; if (bus.busy !== 1'b0)     begin fails++; $display("FAIL rst_mid_busy got %b want 0", bus.busy); end
    tests++; if (bus.full !== 1'b0)     begin fails++; $display("FAIL rst_mid_full got %b want 0", bus.full); end
    tests++; if (bus.overflow !== 1'b0) begin fails++; $display("FAIL rst_mid_ovf got %b want 0", bus.overflow); end
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      tests++;
      if (txd !== 1'b1 || bus.busy !== 1'b0) begin
        fails++; $display("FAIL rst_quiet clk %0d txd=%b busy=%b want 1/0", k, txd, bus.busy);
      end
    end
    tests++; if (rx_q.size() != 0) begin fails++; $display("FAIL rst_no_bytes got %0d want 0", rx_q.size()); end
    a = 8'($urandom_range(255, 0));
    d = 8'($urandom_range(255, 0));
    drive_write(a, d);
    wait_idle(FRAME_CLK + 20, ok);
    tests++; if (!ok) begin fails++; $display("FAIL rst_resume_timeout busy got 1 want 0"); end
    tests++;
    if (rx_q.size() != 2 || rx_q[0] !== a || rx_q[1] !== d || frm_err != 0) begin
      fails++; $display("FAIL rst_resume got %0d bytes err=%0d want %h %h", rx_q.size(), frm_err, a, d);
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_random_frames();
    test_overflow();
    test_full_same_edge_pop();
    test_reset_mid_bit();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx_mux.md
# uart_tx_mux

Transmit-side counterpart of the UART demultiplexer. It accepts (address, data) write requests from on-chip sources such as status and debug registers, queues them in a small FIFO, and serializes each one onto `UART_TXD` as two 8N1 bytes: the address byte, then the data byte. It replaces the constant-high `UART_TXD` tie-off in the top level, so the host can read back loader and NES state over the same link.

## Interface
Parameters:
- `DIVISOR`, default 186: clocks per UART bit (21.48 MHz / 115200). Minimum legal value is 2.
- `FIFO_DEPTH`, default 4: number of queued requests. Must be a power of two, at least 2.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  asynchronous, active-high reset.
- `in_write`  in  1  request strobe; sampled on each rising `clk` edge.
- `in_addr`  in  8  address byte; sampled with `in_write`.
- `in_data`  in  8  data byte; sampled with `in_write`.
- `full`  out  1  FIFO holds `FIFO_DEPTH` entries.
- `overflow`  out  1  sticky flag: a request was dropped.
- `busy`  out  1  a frame is being shifted, or the FIFO is non-empty.
- `UART_TXD`  out  1  serial output, idle high.

## Operation
- **FIFO.** Each entry is 16 bits, {addr, data}. There is a write pointer, a read pointer, and a count from 0 to `FIFO_DEPTH`.
  - A write is accepted when `in_write`=1 and `full`=0, evaluated before the edge.
  - When `in_write`=1 and `full`=1, the request is dropped and `overflow` is set to 1, even if a pop happens on the same edge. `overflow` clears only on `reset`.
  - A simultaneous accepted write and pop leaves the count unchanged.
- **Baud counter.** It loads `DIVISOR`-1 when a bit starts and decrements each clock. A bit ends on the cycle the counter reads 0.
- **FSM states:** IDLE, START, DATA, STOP. A `byte_sel` register holds 0 for the address byte and 1 for the data byte, and a 3-bit `bit_idx` selects the data bit.
  - IDLE: `UART_TXD`=1. If the FIFO is non-empty, pop the head into a 16-bit holding register, set `byte_sel`=0, and go to START.
  - START: `UART_TXD`=0 for one bit period, then go to DATA with `bit_idx`=0.
  - DATA: `UART_TXD` = selected byte[`bit_idx`], LSB first. At the end of each bit, increment `bit_idx`; after bit 7, go to STOP.
  - STOP: `UART_TXD`=1 for one bit period. At the end of the period:
    - if `byte_sel`=0, set `byte_sel`=1 and go to START;
    - else if the FIFO is non-empty, pop, set `byte_sel`=0, and go to START (no idle gap);
    - else go to IDLE.
- **Outputs.** `UART_TXD` is driven from a flop, so it is glitch-free. `busy` = (state≠IDLE) or (count≠0).

## Timing
- Reset values: `UART_TXD`=1, `full`=0, `overflow`=0, `busy`=0, state IDLE, FIFO empty, pointers 0.
- Assertion of `reset` forces these values immediately, including in the middle of a bit. The partial frame and all queued entries are discarded, and nothing resumes after release.
- Latency: a write accepted at edge N into an empty FIFO with the FSM in IDLE is popped at edge N+1. `UART_TXD` falls after edge N+1.
- Each byte lasts exactly 10×`DIVISOR` clocks, and a frame lasts exactly 20×`DIVISOR` clocks.
- Back-to-back frames are contiguous: the next start bit begins on the clock right after the last stop-bit clock.
- `full` and `busy` update on the same edge as the write or pop that changes them.
- Throughput: one request per 20×`DIVISOR` clocks. Sources must respect `full`; pulses of `in_write` that occur while `full`=1 are lost.

## Test plan
- **Single frame.** `DIVISOR`=4, one `in_write` with addr=0x35, data=0x01.
  - Required `UART_TXD`, 4 clocks per bit: 0, 1,0,1,0,1,1,0,0, 1, then 0, 1,0,0,0,0,0,0,0, 1.
  - After that the line stays 1 and `busy` drops after exactly 80 clocks of line activity.
- **Back-to-back.** Write {0x40,0xAA} and {0x41,0x55} on consecutive cycles.
  - Required: four bytes 0x40, 0xAA, 0x41, 0x55 in exactly 160 clocks, with no idle bit between frames.
- **Overflow.** While the first frame is shifting, write 5 further requests in consecutive cycles (`FIFO_DEPTH`=4).
  - Required: `full`=1 after the fourth is queued, the fifth is dropped, and `overflow`=1 and stays 1.
  - Exactly 5 frames are transmitted, in order.
- **Write while full, same-edge pop.** Hold `in_write` on the edge where STOP pops the head from a full FIFO.
  - Required: the request is dropped, `overflow`=1, and the count becomes `FIFO_DEPTH`-1.
- **Reset mid-bit.** Assert `reset` during data bit 3 of the address byte, with 2 entries still queued.
  - Required: `UART_TXD`=1 within the same cycle, and `busy`, `full` and `overflow` all read 0.
  - No further transitions after release until a new write.
